pixel_write_buffer: RTL and testbench

//  Consumer end of the rasterizer address stream (circle/line generators).

---
 rtl/pixel_write_buffer.sv | 142 ++++++++++++++
 tb/tb_pixel_write_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer
//   Consumer end of the rasterizer address stream. Accepted pixels
//   ({address, colour}) are queued in a small FIFO and drained into the
//   frame-buffer SRAM over a we/ack handshake. When the queue nears full,
//   'stop' asks the generator to hold. write_done pulses once the primitive
//   is finished and every queued pixel has been written.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   addr_in, addr_valid   pixel address from generator and its strobe
//   color                 colour sampled together with addr_in
//   prim_done             generator finished the primitive (1-cycle pulse)
//   stop                  backpressure to generator
//   sram_addr/wdata/we    SRAM write request, held until sram_ack
//   sram_ack              SRAM accepted the write this cycle
//   write_done            1-cycle pulse: primitive fully written
//   pix_count             pixels written since the last write_done
//   overflow              sticky: valid push arrived while FIFO full
//
// state | meaning
// IDLE  | no SRAM write outstanding
// WRITE | sram_we high, waiting for sram_ack
module pixel_write_buffer #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int STOP_MARGIN = 2,
  parameter int MAX_ADDR    = 307199
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  input  logic [DATA_W-1:0] color,
  input  logic              prim_done,
  output logic              stop,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  input  logic              sram_ack,
  output logic              write_done,
  output logic [ADDR_W-1:0] pix_count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [0:0] {IDLE, WRITE} state_t;

  state_t            state, state_nxt;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              done_pend;
  logic              empty, full, in_range, push, pop, ack_hit, clr_done;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_range = (addr_in <= ADDR_W'(MAX_ADDR));
  assign push     = addr_valid && !full && in_range;
  // Margin leaves room for pixels the generator emits before it reacts.
  assign stop     = (count >= CNT_W'(DEPTH - STOP_MARGIN));
  assign clr_done = done_pend && empty && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ack_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (sram_ack) begin
          ack_hit = 1'b1;
          // Chain straight into the next entry so writes run back-to-back.
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {addr_in, color};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
    end else if (pop) begin
      {sram_addr, sram_wdata} <= mem[rd_ptr];
      sram_we                 <= 1'b1;
    end else if (ack_hit) begin
      sram_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_count  <= '0;
      done_pend  <= 1'b0;
      write_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      write_done <= clr_done;
      if (clr_done)     pix_count <= '0;
      else if (ack_hit) pix_count <= pix_count + ADDR_W'(1);
      // A prim_done landing while one is already pending is absorbed.
      if (clr_done)       done_pend <= 1'b0;
      else if (prim_done) done_pend <= 1'b1;
      if (addr_valid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
module tb_pixel_write_buffer;

  localparam int MAXA = 307199;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] addr_in = '0;
  logic        addr_valid = 1'b0;
  logic [7:0]  color = '0;
  logic        prim_done = 1'b0;
  logic        stop;
  logic [18:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic        sram_we;
  logic        sram_ack = 1'b0;
  logic        write_done;
  logic [18:0] pix_count;
  logic        overflow;

  pixel_write_buffer dut (
    .clk(tb_clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
    .color(color), .prim_done(prim_done), .stop(stop),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_ack(sram_ack), .write_done(write_done), .pix_count(pix_count),
    .overflow(overflow)
  );

  always #5 tb_clk = ~tb_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_mode = 0;  // 0: ack low, 1: ack high, 2: random

  always @(posedge tb_clk) begin
    #2;
    case (ack_mode)
      0:       sram_ack = 1'b0;
      1:       sram_ack = 1'b1;
      default: sram_ack = 1'($urandom_range(0, 1));
    endcase
  end

  // Write/done monitor at the falling edge: we and ack seen here are exactly
  // what the next rising edge samples, so each hit is one completed write.
  typedef struct {logic [18:0] addr; logic [7:0] data; int cyc;} wr_t;
  wr_t         wr_log[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [18:0] done_pix_prev = '0;
  logic [18:0] pix_prev = '0;

  always @(negedge tb_clk) begin
    cyc = cyc + 1;
    if (sram_we && sram_ack && !rst) wr_log.push_back('{sram_addr, sram_wdata, cyc});
    if (write_done) begin
      done_cnt      = done_cnt + 1;
      done_cyc      = cyc;
      done_pix_prev = pix_prev;
    end
    pix_prev = pix_count;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    addr_valid = 1'b0;
    prim_done  = 1'b0;
    ack_mode   = 0;
    rst        = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_now(input logic [18:0] a, input logic [7:0] c, input logic pd);
    addr_in    = a;
    color      = c;
    addr_valid = 1'b1;
    prim_done  = pd;
    tick();
    addr_valid = 1'b0;
    prim_done  = 1'b0;
  endtask

  typedef struct {logic [18:0] addr; logic [7:0] col; logic exp_wr;} vec_t;
  vec_t vecs[7];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr_base, done_base, exp_pix, acc, occ, t;
    logic [18:0] exp_q[$];
    logic [7:0]  exp_c[$];

    vecs[0] = '{19'd307200, 8'h11, 1'b0};
    vecs[1] = '{19'd307199, 8'h22, 1'b1};
    vecs[2] = '{19'd0,      8'h33, 1'b1};
    vecs[3] = '{19'd524287, 8'h44, 1'b0};
    vecs[4] = '{19'd153920, 8'hFF, 1'b1};
    vecs[5] = '{19'd307201, 8'h55, 1'b0};
    vecs[6] = '{19'd640,    8'h66, 1'b1};

    // Reset state
    do_reset();
    chk("rst_stop", stop, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_done", write_done, 0);
    chk("rst_pix", pix_count, 0);
    chk("rst_ovf", overflow, 0);

    // Reset mid-WRITE with 5 entries queued
    for (int i = 0; i < 6; i++) push_now(19'(100 + i), 8'(i), 1'b0);
    chk("t1_we_before", sram_we, 1);
    chk("t1_addr_before", sram_addr, 100);
    chk("t1_stop_before", stop, 0);
    rst = 1'b1;
    #1;
    chk("t1_we_async", sram_we, 0);
    tick();
    rst = 1'b0;
    chk("t1_stop", stop, 0);
    chk("t1_ovf", overflow, 0);
    wr_base = wr_log.size();
    ack_mode = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("t1_dropped_we", sram_we, 0);
    chk("t1_dropped_writes", wr_log.size() - wr_base, 0);
    chk("t1_dropped_pix", pix_count, 0);

    // Single write, ack one cycle after we
    do_reset();
    push_now(19'd153920, 8'hFF, 1'b0);
    chk("t2_latency_we0", sram_we, 0);
    tick();
    chk("t2_we_cyc1", sram_we, 1);
    chk("t2_addr", sram_addr, 153920);
    chk("t2_wdata", sram_wdata, 8'hFF);
    tick();
    chk("t2_we_cyc2", sram_we, 1);
    chk("t2_addr_stable", sram_addr, 153920);
    ack_mode = 1;
    tick();
    ack_mode = 0;
    chk("t2_we_off", sram_we, 0);
    chk("t2_pix", pix_count, 1);

    // Backpressure and overflow with ack held low
    do_reset();
    wr_base = wr_log.size();
    for (int k = 1; k <= 10; k++) begin
      push_now(19'(2000 + k), 8'(k), 1'b0);
      occ = (k == 1) ? 1 : ((k <= 9) ? k - 1 : 8);
      chk($sformatf("t3_stop_k%0d", k), stop, 32'(occ >= 6));
      chk($sformatf("t3_ovf_k%0d", k), overflow, 32'(k >= 10));
    end
    tick();
    tick();
    chk("t3_ovf_sticky", overflow, 1);
    ack_mode = 1;
    t = 0;
    while (wr_log.size() - wr_base < 9 && t < 40) begin tick(); t++; end
    for (int i = 0; i < 4; i++) tick();
    chk("t3_drain_count", wr_log.size() - wr_base, 9);
    for (int i = 0; i < 9 && wr_base + i < wr_log.size(); i++) begin
      chk($sformatf("t3_drain_addr%0d", i), wr_log[wr_base + i].addr, 2001 + i);
      chk($sformatf("t3_drain_data%0d", i), wr_log[wr_base + i].data, i + 1);
    end
    chk("t3_ovf_after_drain", overflow, 1);
    chk("t3_stop_after_drain", stop, 0);
    do_reset();
    chk("t3_ovf_cleared", overflow, 0);

    // Address range filter (table)
    ack_mode = 1;
    exp_pix = 0;
    for (int v = 0; v < 7; v++) begin
      wr_base = wr_log.size();
      push_now(vecs[v].addr, vecs[v].col, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk($sformatf("t4_written_v%0d", v), wr_log.size() - wr_base, 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr && wr_log.size() > wr_base) begin
        chk($sformatf("t4_addr_v%0d", v), wr_log[wr_base].addr, vecs[v].addr);
        chk($sformatf("t4_data_v%0d", v), wr_log[wr_base].data, vecs[v].col);
        exp_pix++;
      end
      chk($sformatf("t4_pix_v%0d", v), pix_count, exp_pix);
    end
    chk("t4_ovf", overflow, 0);

    // 10 back-to-back writes, prim_done with the 10th push
    do_reset();
    ack_mode = 1;
    wr_base = wr_log.size();
    done_base = done_cnt;
    for (int i = 0; i < 10; i++) push_now(19'(i * 30000 + 5), 8'(i + 1), 1'(i == 9));
    t = 0;
    while (done_cnt == done_base && t < 40) begin tick(); t++; end
    chk("t5_done_timeout", 32'(t < 40), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_writes", wr_log.size() - wr_base, 10);
    for (int i = 0; i < 10 && wr_base + i < wr_log.size(); i++) begin
      chk($sformatf("t5_addr%0d", i), wr_log[wr_base + i].addr, i * 30000 + 5);
      chk($sformatf("t5_data%0d", i), wr_log[wr_base + i].data, i + 1);
    end
    if (wr_log.size() - wr_base == 10) begin
      chk("t5_back_to_back", wr_log[wr_base + 9].cyc - wr_log[wr_base].cyc, 9);
      chk("t5_done_timing", done_cyc, wr_log[wr_base + 9].cyc + 2);
    end
    chk("t5_done_once", done_cnt - done_base, 1);
    chk("t5_pix_before_done", done_pix_prev, 10);
    chk("t5_pix_after", pix_count, 0);
    chk("t5_we_idle", sram_we, 0);

    // prim_done with empty FIFO in IDLE
    do_reset();
    wr_base = wr_log.size();
    done_base = done_cnt;
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
    chk("t6_done_early", write_done, 0);
    tick();
    chk("t6_done_pulse", write_done, 1);
    chk("t6_we", sram_we, 0);
    tick();
    chk("t6_done_end", write_done, 0);
    chk("t6_no_write", wr_log.size() - wr_base, 0);
    chk("t6_done_count", done_cnt - done_base, 1);

    // Repeated prim_done while pending gives a single pulse
    do_reset();
    wr_base = wr_log.size();
    done_base = done_cnt;
    push_now(19'd4242, 8'h5A, 1'b1);
    tick();
    tick();
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
    chk("t7_no_early_done", done_cnt - done_base, 0);
    ack_mode = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("t7_done_once", done_cnt - done_base, 1);
    chk("t7_writes", wr_log.size() - wr_base, 1);
    chk("t7_pix_before_done", done_pix_prev, 1);
    chk("t7_pix_after", pix_count, 0);

    // Randomized traffic against a queue model; generator obeys stop
    do_reset();
    ack_mode = 2;
    wr_base = wr_log.size();
    done_base = done_cnt;
    acc = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        v;
      logic [18:0] a;
      logic [7:0]  col;
      v   = !stop && ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 7) == 0) ? 19'(307200 + $urandom_range(0, 217087))
                                        : 19'($urandom_range(0, MAXA));
      col = 8'($urandom_range(0, 255));
      addr_in = a;
      color = col;
      addr_valid = v;
      tick();
      if (v && a <= 19'(MAXA)) begin
        exp_q.push_back(a);
        exp_c.push_back(col);
        acc++;
      end
      occ = acc - (wr_log.size() - wr_base) - int'(sram_we);
      chk("rnd_stop", stop, 32'(occ >= 6));
      chk("rnd_occ_range", 32'(occ >= 0 && occ <= 8), 1);
      chk("rnd_pix", pix_count, wr_log.size() - wr_base);
    end
    addr_valid = 1'b0;
    ack_mode = 1;
    t = 0;
    while (wr_log.size() - wr_base < acc && t < 50) begin tick(); t++; end
    chk("rnd_drain", wr_log.size() - wr_base, acc);
    for (int i = 0; i < acc && wr_base + i < wr_log.size(); i++) begin
      chk("rnd_wr_addr", wr_log[wr_base + i].addr, exp_q[i]);
      chk("rnd_wr_data", wr_log[wr_base + i].data, exp_c[i]);
    end
    chk("rnd_ovf", overflow, 0);
    tick();
    prim_done = 1'b1;
    tick();
    prim_done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rnd_done_once", done_cnt - done_base, 1);
    chk("rnd_pix_total", done_pix_prev, acc);
    chk("rnd_pix_cleared", pix_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
